// File: rtl/armleocpu_ptw_pkg.sv
// ----------------------------------------------------------------------------
// armleocpu_ptw_pkg
//
// Shared definitions for the Sv32 page table walker and the TLB it feeds:
//   - ptw_state_t : walker state encoding (IDLE, L1, L0, DONE)
//   - tlb_cmd_t   : TLB command codes used by the MMU around the walker
//   - pte_t       : Sv32 page table entry field layout
//                   [31:20] PPN[1], [19:10] PPN[0], [9:8] RSW,
//                   [7] D, [6] A, [5] G, [4] U, [3] X, [2] W, [1] R, [0] V
//   - small PTE classification helpers shared by both walk levels
// ----------------------------------------------------------------------------
package armleocpu_ptw_pkg;

    typedef enum logic [1:0] {
        PTW_IDLE = 2'd0,
        PTW_L1   = 2'd1,
        PTW_L0   = 2'd2,
        PTW_DONE = 2'd3
    } ptw_state_t;

    typedef enum logic [1:0] {
        TLB_CMD_NONE       = 2'd0,
        TLB_CMD_RESOLVE    = 2'd1,
        TLB_CMD_NEW_ENTRY  = 2'd2,
        TLB_CMD_INVALIDATE = 2'd3
    } tlb_cmd_t;

    typedef struct packed {
        logic [11:0] ppn1;
        logic [9:0]  ppn0;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;

    // Invalid entry, or the reserved write-only encoding.
    function automatic logic pte_is_invalid(input pte_t pte);
        return !pte.v || (!pte.r && pte.w);
    endfunction

    // A valid entry with any of R/X set terminates the walk.
    function automatic logic pte_is_leaf(input pte_t pte);
        return pte.r || pte.x;
    endfunction

    // Megapage leaves must have PPN[0] clear.
    function automatic logic pte_megapage_misaligned(input pte_t pte);
        return pte.ppn0 != 10'd0;
    endfunction

endpackage

// File: rtl/armleocpu_ptw.sv
// ----------------------------------------------------------------------------
// armleocpu_ptw
//
// Sv32 two-level hardware page table walker. On a request in IDLE it reads
// the root-level PTE, then either finishes (megapage leaf / fault) or reads
// the leaf-level PTE, and reports the translation for TLB refill.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   resolve_request       : start a walk (only looked at in IDLE)
//   resolve_vpn[19:0]     : {vpn1, vpn0}, held by requester until done
//   satp_ppn[21:0]        : root page table PPN, held during the walk
//   resolve_done          : one-cycle pulse, results below valid
//   resolve_pagefault     : translation fault
//   resolve_accessfault   : bus error while reading a PTE
//   resolve_metadata[7:0] : leaf PTE[7:0] (V R W X U G A D)
//   resolve_ptag[21:0]    : physical page number of the translation
//   mem_req               : PTE read request, high in L1 and L0
//   mem_address[33:0]     : physical byte address of the PTE
//   mem_ack               : read response strobe
//   mem_readdata[31:0]    : PTE read data
//   mem_error             : bus error for the read being acknowledged
// ----------------------------------------------------------------------------
module armleocpu_ptw
    import armleocpu_ptw_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        resolve_request,
    input  logic [19:0] resolve_vpn,
    input  logic [21:0] satp_ppn,

    output logic        resolve_done,
    output logic        resolve_pagefault,
    output logic        resolve_accessfault,
    output logic [7:0]  resolve_metadata,
    output logic [21:0] resolve_ptag,

    output logic        mem_req,
    output logic [33:0] mem_address,
    input  logic        mem_ack,
    input  logic [31:0] mem_readdata,
    input  logic        mem_error
);

    ptw_state_t  state;
    logic [21:0] table_ppn;     // next-level table PPN latched from the L1 pointer

    logic [9:0]  vpn1;
    logic [9:0]  vpn0;
    pte_t        pte;
    logic [7:0]  pte_metadata;
    logic        unused_rsw;

    assign vpn1 = resolve_vpn[19:10];
    assign vpn0 = resolve_vpn[9:0];
    assign pte  = pte_t'(mem_readdata);

    assign pte_metadata = {pte.d, pte.a, pte.g, pte.u, pte.x, pte.w, pte.r, pte.v};

    // RSW bits are software-owned and carry no meaning for translation.
    assign unused_rsw = ^pte.rsw;

    // Request and address are pure decodes of state; both stay stable while
    // waiting for the ack because the requester holds vpn/satp steady.
    always_comb begin
        mem_req     = 1'b0;
        mem_address = {satp_ppn, vpn1, 2'b00};
        case (state)
            PTW_L1: begin
                mem_req     = 1'b1;
                mem_address = {satp_ppn, vpn1, 2'b00};
            end
            PTW_L0: begin
                mem_req     = 1'b1;
                mem_address = {table_ppn, vpn0, 2'b00};
            end
            default: begin
                mem_req     = 1'b0;
                mem_address = {satp_ppn, vpn1, 2'b00};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= PTW_IDLE;
            resolve_done        <= 1'b0;
            resolve_pagefault   <= 1'b0;
            resolve_accessfault <= 1'b0;
            resolve_metadata    <= 8'd0;
            resolve_ptag        <= 22'd0;
            table_ppn           <= 22'd0;
        end else begin
            // resolve_done only rises on the edge that enters DONE.
            resolve_done <= 1'b0;
            case (state)
                PTW_IDLE: begin
                    if (resolve_request) begin
                        state <= PTW_L1;
                    end
                end

                PTW_L1: begin
                    if (mem_ack) begin
                        if (mem_error) begin
                            state               <= PTW_DONE;
                            resolve_done        <= 1'b1;
                            resolve_accessfault <= 1'b1;
                            resolve_pagefault   <= 1'b0;
                        end else if (pte_is_invalid(pte) ||
                                     (pte_is_leaf(pte) && pte_megapage_misaligned(pte))) begin
                            state               <= PTW_DONE;
                            resolve_done        <= 1'b1;
                            resolve_accessfault <= 1'b0;
                            resolve_pagefault   <= 1'b1;
                        end else if (pte_is_leaf(pte)) begin
                            // Megapage: the low tag bits come from the virtual address.
                            state               <= PTW_DONE;
                            resolve_done        <= 1'b1;
                            resolve_accessfault <= 1'b0;
                            resolve_pagefault   <= 1'b0;
                            resolve_metadata    <= pte_metadata;
                            resolve_ptag        <= {pte.ppn1, vpn0};
                        end else begin
                            state     <= PTW_L0;
                            table_ppn <= {pte.ppn1, pte.ppn0};
                        end
                    end
                end

                PTW_L0: begin
                    if (mem_ack) begin
                        state        <= PTW_DONE;
                        resolve_done <= 1'b1;
                        if (mem_error) begin
                            resolve_accessfault <= 1'b1;
                            resolve_pagefault   <= 1'b0;
                        end else if (pte_is_invalid(pte) || !pte_is_leaf(pte)) begin
                            // A pointer at the last level has nowhere to go.
                            resolve_accessfault <= 1'b0;
                            resolve_pagefault   <= 1'b1;
                        end else begin
                            resolve_accessfault <= 1'b0;
                            resolve_pagefault   <= 1'b0;
                            resolve_metadata    <= pte_metadata;
                            resolve_ptag        <= {pte.ppn1, pte.ppn0};
                        end
                    end
                end

                PTW_DONE: begin
                    state <= PTW_IDLE;
                end

                default: begin
                    state <= PTW_IDLE;
                end
            endcase
        end
    end

endmodule
